// File: rtl/matrix_pkg.sv
// Shared widths, event layout and scan FSM states for the button-matrix scanner.
// Pure declarations; no timing or flow-control behaviour of its own.
package matrix_pkg;
    localparam int ROWS  = 13;
    localparam int COLS  = 18;
    localparam int ROW_W = 4;
    localparam int COL_W = 5;
    localparam int EVT_W = 10;

    localparam int EVT_COL_LSB   = 0;
    localparam int EVT_ROW_LSB   = EVT_COL_LSB + COL_W;
    localparam int EVT_PRESS_BIT = EVT_ROW_LSB + ROW_W;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        EMIT,
        GAP
    } scan_state_t;

    function automatic logic [EVT_W-1:0] pack_evt(input logic pressed,
                                                  input logic [ROW_W-1:0] r,
                                                  input logic [COL_W-1:0] c);
        logic [EVT_W-1:0] e;
        e = '0;
        e[EVT_PRESS_BIT]           = pressed;
        e[EVT_ROW_LSB +: ROW_W]    = r;
        e[EVT_COL_LSB +: COL_W]    = c;
        return e;
    endfunction
endpackage

// File: rtl/event_fifo.sv
// Synchronous event FIFO; head is combinational, flags update the cycle after push/pop.
// Push while full is refused unless a pop happens in the same cycle; pop while empty is ignored.
module event_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    // A same-cycle pop frees the slot being written, so a full FIFO still accepts.
    assign do_push  = push && (!full || do_pop);
    assign head_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

// File: rtl/matrix_scan_sequencer.sv
// Autonomous row scanner with frame-to-frame debounce, key-state map and press/release event FIFO.
// Event pushed on its EMIT cycle, visible next cycle; a full FIFO drops the event and sets overflow.
module matrix_scan_sequencer #(
    parameter int ROWS          = matrix_pkg::ROWS,
    parameter int COLS          = matrix_pkg::COLS,
    parameter int SETTLE_CYCLES = 48,
    parameter int FRAME_GAP     = 48000,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         enable,
    input  logic [COLS-1:0]              col_in,
    output logic [ROWS-1:0]              row,
    output logic [matrix_pkg::EVT_W-1:0] evt_data,
    output logic                         evt_valid,
    input  logic                         evt_pop,
    output logic                         overflow,
    input  logic                         clear_ovf,
    output logic                         frame_done,
    input  logic [matrix_pkg::ROW_W-1:0] rd_row,
    output logic [COLS-1:0]              rd_cols
);
    import matrix_pkg::*;

    localparam int CNT_W = $clog2(FRAME_GAP + SETTLE_CYCLES + COLS + 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(FRAME_GAP - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] COL_LAST    = CNT_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(ROWS - 1);

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] ridx_q, ridx_d;
    logic [ROWS-1:0]  row_q, row_d;
    logic             frame_done_q;
    logic             ovf_q;

    logic [COLS-1:0]  col_meta, col_sync;
    logic [COLS-1:0]  prev_q   [ROWS];
    logic [COLS-1:0]  stable_q [ROWS];
    logic [COLS-1:0]  chg_q;
    logic [COLS-1:0]  raw, chg;
    logic [COL_W-1:0] col_idx;
    logic             evt_push, evt_drop;
    logic [EVT_W-1:0] push_dat;
    logic             fifo_full, fifo_empty;

    assign raw      = ~col_sync;
    // Change only when this frame agrees with the last one and differs from the stable map.
    assign chg      = ~(raw ^ prev_q[ridx_q]) & (raw ^ stable_q[ridx_q]);
    assign col_idx  = COL_W'(cnt_q);
    assign evt_push = (state_q == EMIT) && chg_q[col_idx];
    assign push_dat = pack_evt(~stable_q[ridx_q][col_idx], ridx_q, col_idx);
    assign evt_drop = evt_push && fifo_full && !(evt_pop && !fifo_empty);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        ridx_d  = ridx_q;
        case (state_q)
            IDLE: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = cnt_q;
                    if (enable) begin
                        state_d = SETTLE;
                        cnt_d   = '0;
                        ridx_d  = '0;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                end
            end
            SAMPLE: begin
                cnt_d   = '0;
                state_d = (|chg) ? EMIT : GAP;
            end
            EMIT: begin
                if (cnt_q == COL_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                cnt_d = '0;
                if (ridx_q == ROW_LAST) begin
                    state_d = IDLE;
                end else begin
                    state_d = SETTLE;
                    ridx_d  = ridx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Row drive is registered from the next state so it never glitches low.
        row_d = '1;
        if (state_d == SETTLE || state_d == SAMPLE) row_d = ~(ROWS'(1) << ridx_d);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ridx_q       <= '0;
            row_q        <= '1;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
            col_meta     <= '1;
            col_sync     <= '1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ridx_q       <= ridx_d;
            row_q        <= row_d;
            frame_done_q <= (state_q == GAP) && (ridx_q == ROW_LAST);
            col_meta     <= col_in;
            col_sync     <= col_meta;
            if (evt_drop)       ovf_q <= 1'b1;
            else if (clear_ovf) ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            chg_q <= '0;
            for (int r = 0; r < ROWS; r++) begin
                prev_q[r]   <= '0;
                stable_q[r] <= '0;
            end
        end else begin
            if (state_q == SAMPLE) begin
                chg_q          <= chg;
                prev_q[ridx_q] <= raw;
            end
            if (evt_push) stable_q[ridx_q][col_idx] <= ~stable_q[ridx_q][col_idx];
        end
    end

    event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (evt_push),
        .push_dat (push_dat),
        .pop      (evt_pop),
        .head_dat (evt_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign row        = row_q;
    assign evt_valid  = ~fifo_empty;
    assign overflow   = ovf_q;
    assign frame_done = frame_done_q;
    assign rd_cols    = (int'(rd_row) < ROWS) ? stable_q[rd_row] : '0;
endmodule

// File: tb/tb_matrix_scan_sequencer.sv
// Directed bench for matrix_scan_sequencer with a shortened frame gap and a key-matrix model.
// Inputs change on the falling edge; outputs are compared on the falling edge or just after it.
module tb_matrix_scan_sequencer;
    localparam int GAPC = 50;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic [17:0] col_in;
    logic [12:0] row;
    logic [9:0]  evt_data;
    logic        evt_valid;
    logic        evt_pop;
    logic        overflow;
    logic        clear_ovf;
    logic        frame_done;
    logic [3:0]  rd_row;
    logic [17:0] rd_cols;

    logic [17:0] keys [13];
    logic [9:0]  got [$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        col_in = '1;
        for (int r = 0; r < 13; r++) if (!row[r]) col_in = col_in & ~keys[r];
    end

    matrix_scan_sequencer #(
        .ROWS(13), .COLS(18), .SETTLE_CYCLES(48), .FRAME_GAP(GAPC), .FIFO_DEPTH(16)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .col_in(col_in), .row(row),
        .evt_data(evt_data), .evt_valid(evt_valid), .evt_pop(evt_pop),
        .overflow(overflow), .clear_ovf(clear_ovf), .frame_done(frame_done),
        .rd_row(rd_row), .rd_cols(rd_cols)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frame(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 5000);
        check(tag, frame_done, 1);
    endtask

    task automatic wait_row(input logic [12:0] want, input string tag);
        int n = 0;
        while (row !== want && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, row, want);
    endtask

    task automatic pop_one();
        evt_pop = 1'b1;
        @(negedge clk);
        evt_pop = 1'b0;
    endtask

    task automatic read_row(input logic [3:0] r, input logic [17:0] exp, input string tag);
        rd_row = r;
        #1;
        check(tag, rd_cols, exp);
    endtask

    // Runs one frame while draining events as they appear; returns row-12 period.
    task automatic frame_drain(output int period);
        int n = 0;
        int t0 = -1;
        got.delete();
        do begin
            @(negedge clk);
            n++;
            if (row === 13'h0FFF && t0 < 0) t0 = n;
            if (evt_valid) begin
                got.push_back(evt_data);
                evt_pop = 1'b1;
            end else begin
                evt_pop = 1'b0;
            end
        end while (!frame_done && n < 5000);
        evt_pop = 1'b0;
        check("drain_frame_done", frame_done, 1);
        period = n - t0;
    endtask

    initial begin
        int n;
        int per;
        int unsigned t_fd;
        logic [12:0] exp_row;

        resetn = 1'b0; enable = 1'b1; evt_pop = 1'b0; clear_ovf = 1'b0; rd_row = 4'd0;
        for (int r = 0; r < 13; r++) keys[r] = '0;
        repeat (3) @(negedge clk);
        check("rst_row", row, 13'h1FFF);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_evt_data", evt_data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_rd_cols", rd_cols, 0);

        // Idle scan: first row after FRAME_GAP, 49 low cycles per row, one high between.
        resetn = 1'b1;
        n = 0;
        while (row === 13'h1FFF && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("first_row_delay", n, GAPC);
        for (int r = 0; r < 13; r++) begin
            exp_row = ~(13'd1 << r);
            n = 0;
            while (row === exp_row && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("row_low_cycles", n, 49);
            check("row_gap_high", row, 13'h1FFF);
            @(negedge clk);
        end
        check("frame_done_pulse", frame_done, 1);
        t_fd = cyc;
        wait_frame("frame2_done");
        check("frame_period", cyc - t_fd, 650 + GAPC);
        check("idle_no_event", evt_valid, 0);

        // Single key (3,7): press needs two agreeing frames, release likewise.
        keys[3][7] = 1'b1;
        wait_frame("key_f1");
        check("key_f1_no_evt", evt_valid, 0);
        read_row(4'd3, 18'h00000, "key_f1_rd");
        wait_frame("key_f2");
        check("key_f2_valid", evt_valid, 1);
        check("key_press_evt", evt_data, 10'h267);
        read_row(4'd3, 18'h00080, "key_f2_rd");
        read_row(4'd13, 18'h00000, "rd_row_oob");
        pop_one();
        check("key_popped", evt_valid, 0);
        pop_one();
        check("pop_empty", evt_valid, 0);
        keys[3][7] = 1'b0;
        wait_frame("rel_f1");
        check("rel_f1_no_evt", evt_valid, 0);
        read_row(4'd3, 18'h00080, "rel_f1_rd");
        wait_frame("rel_f2");
        check("rel_valid", evt_valid, 1);
        check("rel_evt", evt_data, 10'h067);
        read_row(4'd3, 18'h00000, "rel_f2_rd");
        pop_one();

        // Bounce at (5,0): level flips every frame, never two agreeing frames.
        for (int f = 0; f < 6; f++) begin
            keys[5][0] = (f % 2 == 0);
            wait_frame("bounce_frame");
            check("bounce_no_evt", evt_valid, 0);
        end
        read_row(4'd5, 18'h00000, "bounce_rd");

        // 17 presses in row 1 with no pops: 16 queued, one dropped.
        keys[1] = 18'h1FFFF;
        wait_frame("ovf_f1");
        check("ovf_f1_no_evt", evt_valid, 0);
        wait_frame("ovf_f2");
        check("ovf_set", overflow, 1);
        check("ovf_head", evt_data, 10'h220);
        read_row(4'd1, 18'h1FFFF, "ovf_rd");
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Push of (1,17) coincides with a pop while full.
        keys[1][17] = 1'b1;
        wait_frame("pp_f1");
        wait_row(13'h1FFD, "pp_row1_low");
        wait_row(13'h1FFF, "pp_row1_emit");
        repeat (17) @(negedge clk);
        evt_pop = 1'b1;
        @(negedge clk);
        evt_pop = 1'b0;
        wait_frame("pp_f2");
        check("pp_no_ovf", overflow, 0);
        read_row(4'd1, 18'h3FFFF, "pp_rd");
        for (int i = 0; i < 16; i++) begin
            check("pp_drain_valid", evt_valid, 1);
            check("pp_drain_data", evt_data, 10'h220 | ((i < 15) ? i + 1 : 17));
            pop_one();
        end
        check("pp_drained", evt_valid, 0);

        // Full row 12: 18 events in column order, row period stretched by EMIT.
        keys[12] = '1;
        frame_drain(per);
        check("r12_quiet_period", per, 50);
        check("r12_f1_events", got.size(), 0);
        keys[2][2] = 1'b1;
        frame_drain(per);
        check("r12_emit_period", per, 68);
        check("r12_events", got.size(), 18);
        for (int c = 0; c < 18 && c < got.size(); c++) check("r12_evt", got[c], 10'h380 | c);
        check("r12_no_ovf", overflow, 0);

        // Reset during SETTLE of row 6 with an event pending.
        wait_row(13'h1FBF, "rst_row6_low");
        repeat (5) @(negedge clk);
        check("rst_row6_hold", row, 13'h1FBF);
        check("pending_evt", evt_data, 10'h242);
        #2 resetn = 1'b0;
        #1;
        check("arst_row", row, 13'h1FFF);
        check("arst_evt_valid", evt_valid, 0);
        check("arst_evt_data", evt_data, 0);
        read_row(4'd2, 18'h00000, "arst_rd");
        @(negedge clk);
        resetn = 1'b1;
        n = 0;
        while (row === 13'h1FFF && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("restart_delay", n, GAPC);
        check("restart_row0", row, 13'h1FFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
